// File: rtl/i2c_entity.sv
// Single-master I2C controller for register-addressed slaves with a 16-bit pointer.
// Each bit is four DIV-clock phases; SCL/SDA are open-drain via external tristate buffers.
module i2c_entity #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 400_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_read,
    input  logic [6:0]  slave_adress,
    input  logic [15:0] register_address,
    input  logic [9:0]  nb_of_bytes,
    input  logic [7:0]  data_in,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SCL_out,
    output logic        SDA_out,
    output logic        SCL_t,
    output logic        SDA_t,
    output logic        ready,
    output logic        error_out,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        data_req
);
    localparam int DIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] C_MID  = CW'(DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND_BYTE, S_GET_ACK,
        S_RESTART, S_READ_BYTE, S_SEND_ACK, S_STOP
    } state_t;

    typedef enum logic [2:0] {
        B_ADDR_W, B_REG_HI, B_REG_LO, B_DATA_W, B_ADDR_R
    } stage_t;

    state_t      r_state, w_state_next;
    stage_t      r_stage;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_phase;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [9:0]  r_left;
    logic [6:0]  r_addr;
    logic [15:0] r_reg;
    logic        r_read;
    logic        r_ack;
    logic        r_error;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic        r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;

    logic w_hold, w_bit_done, w_sample;

    // Phase 1 has just released SCL: wait there while a slave stretches the clock.
    assign w_hold     = (r_phase == 2'd1) && !r_scl_sync;
    assign w_bit_done = (r_phase == 2'd3) && (r_cnt == C_LAST);
    assign w_sample   = (r_phase == 2'd2) && (r_cnt == C_MID);

    assign SCL_out    = 1'b0;
    assign SDA_out    = 1'b0;
    assign error_out  = r_error;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_START;
            S_START:     if (w_bit_done) w_state_next = S_SEND_BYTE;
            S_SEND_BYTE: if (w_bit_done && r_bit == 3'd0) w_state_next = S_GET_ACK;
            S_GET_ACK: begin
                if (w_bit_done) begin
                    if (!r_ack) begin
                        w_state_next = S_STOP;
                    end else begin
                        case (r_stage)
                            B_ADDR_W, B_REG_HI: w_state_next = S_SEND_BYTE;
                            B_REG_LO: begin
                                if (r_left == 10'd0)  w_state_next = S_STOP;
                                else if (r_read)      w_state_next = S_RESTART;
                                else                  w_state_next = S_SEND_BYTE;
                            end
                            B_DATA_W: w_state_next = (r_left == 10'd1) ? S_STOP : S_SEND_BYTE;
                            B_ADDR_R: w_state_next = S_READ_BYTE;
                            default:  w_state_next = S_STOP;
                        endcase
                    end
                end
            end
            S_RESTART:   if (w_bit_done) w_state_next = S_SEND_BYTE;
            S_READ_BYTE: if (w_bit_done && r_bit == 3'd0) w_state_next = S_SEND_ACK;
            S_SEND_ACK:  if (w_bit_done) w_state_next = (r_left == 10'd1) ? S_STOP : S_READ_BYTE;
            S_STOP:      if (w_bit_done) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = (r_state == S_IDLE);
        SCL_t    = 1'b1;
        SDA_t    = 1'b1;
        data_req = (r_state == S_GET_ACK) && w_bit_done && r_ack &&
                   (((r_stage == B_REG_LO) && !r_read && (r_left != 10'd0)) ||
                    ((r_stage == B_DATA_W) && (r_left != 10'd1)));
        case (r_state)
            S_IDLE: ;
            S_START: begin
                SCL_t = (r_phase != 2'd3);
                SDA_t = (r_phase < 2'd2);
            end
            S_RESTART: begin
                SCL_t = (r_phase == 2'd1) || (r_phase == 2'd2);
                SDA_t = (r_phase < 2'd2);
            end
            S_SEND_BYTE: begin
                SCL_t = (r_phase == 2'd1) || (r_phase == 2'd2);
                SDA_t = r_shift[7];
            end
            S_GET_ACK, S_READ_BYTE: begin
                SCL_t = (r_phase == 2'd1) || (r_phase == 2'd2);
            end
            S_SEND_ACK: begin
                SCL_t = (r_phase == 2'd1) || (r_phase == 2'd2);
                SDA_t = (r_left == 10'd1);
            end
            S_STOP: begin
                SCL_t = (r_phase != 2'd0);
                SDA_t = (r_phase == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_meta   <= 1'b1;
            r_scl_sync   <= 1'b1;
            r_sda_meta   <= 1'b1;
            r_sda_sync   <= 1'b1;
            r_cnt        <= '0;
            r_phase      <= 2'd0;
            r_bit        <= 3'd7;
            r_shift      <= 8'h00;
            r_stage      <= B_ADDR_W;
            r_left       <= 10'd0;
            r_addr       <= 7'h00;
            r_reg        <= 16'h0000;
            r_read       <= 1'b0;
            r_ack        <= 1'b0;
            r_error      <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
        end else begin
            r_scl_meta   <= SCL_in;
            r_scl_sync   <= r_scl_meta;
            r_sda_meta   <= SDA_in;
            r_sda_sync   <= r_sda_meta;
            r_data_valid <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cnt   <= '0;
                r_phase <= 2'd0;
            end else if (!w_hold) begin
                if (r_cnt == C_LAST) begin
                    r_cnt   <= '0;
                    r_phase <= r_phase + 2'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= slave_adress;
                        r_reg   <= register_address;
                        r_read  <= is_read;
                        r_left  <= nb_of_bytes;
                        r_error <= 1'b0;
                        r_shift <= {slave_adress, 1'b0};
                        r_stage <= B_ADDR_W;
                        r_bit   <= 3'd7;
                    end
                end
                S_SEND_BYTE: begin
                    if (w_bit_done) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bit   <= r_bit - 3'd1;
                    end
                end
                S_GET_ACK: begin
                    if (w_sample) r_ack <= !r_sda_sync;
                    if (w_bit_done) begin
                        if (!r_ack) begin
                            r_error <= 1'b1;
                        end else begin
                            case (r_stage)
                                B_ADDR_W: begin
                                    r_shift <= r_reg[15:8];
                                    r_stage <= B_REG_HI;
                                end
                                B_REG_HI: begin
                                    r_shift <= r_reg[7:0];
                                    r_stage <= B_REG_LO;
                                end
                                B_REG_LO: begin
                                    if (r_left != 10'd0) begin
                                        if (r_read) begin
                                            r_shift <= {r_addr, 1'b1};
                                            r_stage <= B_ADDR_R;
                                        end else begin
                                            r_shift <= data_in;
                                            r_stage <= B_DATA_W;
                                        end
                                    end
                                end
                                B_DATA_W: begin
                                    r_left <= r_left - 10'd1;
                                    if (r_left != 10'd1) r_shift <= data_in;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_READ_BYTE: begin
                    if (w_sample) begin
                        r_shift <= {r_shift[6:0], r_sda_sync};
                        if (r_bit == 3'd0) begin
                            r_data_out   <= {r_shift[6:0], r_sda_sync};
                            r_data_valid <= 1'b1;
                        end
                    end
                    if (w_bit_done) r_bit <= r_bit - 3'd1;
                end
                S_SEND_ACK: begin
                    if (w_bit_done) r_left <= r_left - 10'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_entity.sv
// Directed bench for i2c_entity: behavioural slave on an open-drain bus, bus-event log
// compared against hand-written expected sequences per vector.
module tb_i2c_entity;
    localparam int L_A = 256, L_N = 257, L_S = 258, L_P = 259, X = -1;
    localparam int NV = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_read = 1'b0;
    logic [6:0]  slave_adress = 7'h00;
    logic [15:0] register_address = 16'h0000;
    logic [9:0]  nb_of_bytes = 10'd0;
    logic [7:0]  data_in = 8'h00;
    logic        SCL_out, SDA_out, SCL_t, SDA_t, ready, error_out, data_valid, data_req;
    logic [7:0]  data_out;
    logic        s_scl_o = 1'b1, s_sda_o = 1'b1;
    logic        bus_scl, bus_sda;

    assign bus_scl = SCL_t & s_scl_o;
    assign bus_sda = SDA_t & s_sda_o;

    always #5 clock = ~clock;

    i2c_entity #(.CLK_FREQ_HZ(8_000_000), .I2C_FREQ_HZ(400_000)) dut (
        .clock(clock), .reset(reset), .start(start), .is_read(is_read),
        .slave_adress(slave_adress), .register_address(register_address),
        .nb_of_bytes(nb_of_bytes), .data_in(data_in),
        .SCL_in(bus_scl), .SDA_in(bus_sda),
        .SCL_out(SCL_out), .SDA_out(SDA_out), .SCL_t(SCL_t), .SDA_t(SDA_t),
        .ready(ready), .error_out(error_out), .data_out(data_out),
        .data_valid(data_valid), .data_req(data_req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave configuration for the current vector
    bit         cur_present = 1'b1;
    bit         cur_stretch = 1'b0;
    logic [7:0] cur_rd0 = 8'h00, cur_rd1 = 8'h00;

    int         bus_log[$];
    logic [7:0] dv_q[$];
    int         req_total = 0;

    // Behavioural slave at 0x29 and bus logger, sampled on the falling clock edge.
    initial begin
        int         rcnt;
        logic [7:0] sh, tx;
        bit         first, addr_ok, rd, txing, ackbit, stretched;
        int         idx, stretch_left;
        logic       p_scl, p_sda, c_scl, c_sda;
        rcnt = 0; sh = 8'h00; tx = 8'h00; first = 0; addr_ok = 0; rd = 0; txing = 0;
        ackbit = 1; stretched = 0; idx = 0; stretch_left = 0; p_scl = 1; p_sda = 1;
        forever begin
            @(negedge clock);
            if (reset) begin
                rcnt = 0; first = 0; addr_ok = 0; rd = 0; txing = 0; stretch_left = 0;
                s_sda_o = 1'b1; s_scl_o = 1'b1; p_scl = 1; p_sda = 1;
            end else begin
                c_scl = bus_scl;
                c_sda = bus_sda;
                if (stretch_left > 0) begin
                    stretch_left--;
                    if (stretch_left == 0) s_scl_o = 1'b1;
                end
                if (p_scl && c_scl && p_sda && !c_sda) begin
                    bus_log.push_back(L_S);
                    rcnt = 0; first = 1; rd = 0; txing = 0; idx = 0; s_sda_o = 1'b1;
                end else if (p_scl && c_scl && !p_sda && c_sda) begin
                    bus_log.push_back(L_P);
                    rcnt = 0; rd = 0; txing = 0; addr_ok = 0; s_sda_o = 1'b1;
                end else if (!p_scl && c_scl) begin
                    rcnt++;
                    if (rcnt <= 8) sh = {sh[6:0], c_sda};
                    else if (rcnt == 9) begin
                        ackbit = c_sda;
                        bus_log.push_back(c_sda ? L_N : L_A);
                    end
                end else if (p_scl && !c_scl) begin
                    if (cur_stretch && !stretched && rcnt == 1) begin
                        stretched = 1; s_scl_o = 1'b0; stretch_left = 500;
                    end
                    if (rcnt == 8) begin
                        bus_log.push_back(int'(sh));
                        if (first) begin
                            first   = 0;
                            addr_ok = cur_present && (sh[7:1] == 7'h29);
                            rd      = sh[0];
                            s_sda_o = !addr_ok;
                        end else if (txing) begin
                            s_sda_o = 1'b1;
                        end else begin
                            s_sda_o = !addr_ok;
                        end
                    end else if (rcnt == 9) begin
                        rcnt = 0;
                        if (addr_ok && rd && !ackbit) begin
                            txing = 1;
                            tx = (idx == 0) ? cur_rd0 : (idx == 1) ? cur_rd1 : 8'hFF;
                            idx++;
                            s_sda_o = tx[7];
                        end else begin
                            txing = 0;
                            s_sda_o = 1'b1;
                        end
                    end else if (rcnt >= 1 && rcnt <= 7 && txing) begin
                        s_sda_o = tx[3'(7 - rcnt)];
                    end
                end
                p_scl = c_scl;
                p_sda = c_sda;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (data_valid) dv_q.push_back(data_out);
            if (data_req) req_total++;
        end
    end

    typedef struct {
        bit         rd;
        logic [6:0] addr;
        logic [15:0] rg;
        int         nb;
        logic [7:0] din;
        bit         present;
        bit         stretch;
        bit         dbl;
        logic [7:0] s0, s1;
        int         min_cyc;
        bit         exp_err;
        int         exp_dv;
        int         exp_req;
        int         exp_len;
    } vec_t;

    vec_t vecs[NV];
    int   exp_logs[NV][16];

    function automatic vec_t mk(input bit rd, input logic [6:0] addr, input logic [15:0] rg,
                                input int nb, input logic [7:0] din, input bit present,
                                input bit stretch, input bit dbl, input logic [7:0] s0,
                                input logic [7:0] s1, input int min_cyc, input bit exp_err,
                                input int exp_dv, input int exp_req, input int exp_len);
        vec_t v;
        v.rd = rd; v.addr = addr; v.rg = rg; v.nb = nb; v.din = din; v.present = present;
        v.stretch = stretch; v.dbl = dbl; v.s0 = s0; v.s1 = s1; v.min_cyc = min_cyc;
        v.exp_err = exp_err; v.exp_dv = exp_dv; v.exp_req = exp_req; v.exp_len = exp_len;
        return v;
    endfunction

    task automatic run_vec(input int n);
        vec_t v;
        int   lb, db, rb, cyc;
        v  = vecs[n];
        cur_present = v.present; cur_stretch = v.stretch; cur_rd0 = v.s0; cur_rd1 = v.s1;
        lb = bus_log.size(); db = dv_q.size(); rb = req_total;
        @(negedge clock);
        is_read = v.rd; slave_adress = v.addr; register_address = v.rg;
        nb_of_bytes = 10'(v.nb); data_in = v.din; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk($sformatf("v%0d_ready_low", n), int'(ready), 0);
        chk($sformatf("v%0d_err_cleared", n), int'(error_out), 0);
        cyc = 0;
        while (!ready && cyc < 20000) begin
            if (v.dbl && cyc == 60) begin
                start = 1'b1; is_read = 1'b1; slave_adress = 7'h7F;
                register_address = 16'hFFFF; nb_of_bytes = 10'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("v%0d_done", n), int'(ready), 1);
        repeat (3) @(negedge clock);
        chk($sformatf("v%0d_error", n), int'(error_out), int'(v.exp_err));
        chk($sformatf("v%0d_dv_count", n), dv_q.size() - db, v.exp_dv);
        if (v.exp_dv >= 1)
            chk($sformatf("v%0d_data0", n), (dv_q.size() > db) ? int'(dv_q[db]) : X, int'(v.s0));
        if (v.exp_dv >= 2)
            chk($sformatf("v%0d_data1", n), (dv_q.size() > db + 1) ? int'(dv_q[db + 1]) : X, int'(v.s1));
        chk($sformatf("v%0d_req_count", n), req_total - rb, v.exp_req);
        chk($sformatf("v%0d_log_len", n), bus_log.size() - lb, v.exp_len);
        for (int k = 0; k < v.exp_len; k++)
            chk($sformatf("v%0d_log%0d", n, k),
                (bus_log.size() > lb + k) ? bus_log[lb + k] : X, exp_logs[n][k]);
        if (v.min_cyc > 0)
            chk($sformatf("v%0d_stretch_stall", n), int'(cyc >= v.min_cyc), 1);
        $display("[TB] vec %0d: rd=%0d addr=0x%0h reg=0x%0h nb=%0d cycles=%0d events=%0d err=%0d",
                 n, v.rd, v.addr, v.rg, v.nb, cyc, bus_log.size() - lb, error_out);
    endtask

    initial begin
        int cyc;
        //         rd addr    reg       nb din    pres st dbl s0     s1     min  err dv req len
        vecs[0] = mk(1, 7'h29, 16'hA6A6, 2, 8'h00, 1, 0, 0, 8'h12, 8'h34, 0,    0,  2, 0, 15);
        vecs[1] = mk(0, 7'h29, 16'h0010, 1, 8'h02, 1, 0, 0, 8'h00, 8'h00, 0,    0,  0, 1, 10);
        vecs[2] = mk(1, 7'h29, 16'hA6A6, 2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,    1,  0, 0, 4);
        vecs[3] = mk(1, 7'h29, 16'h0001, 1, 8'h00, 1, 1, 0, 8'h5A, 8'h00, 1450, 0,  1, 0, 13);
        vecs[4] = mk(1, 7'h29, 16'h1234, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0,    0,  0, 0, 8);
        vecs[5] = mk(0, 7'h29, 16'hABCD, 2, 8'h77, 1, 0, 0, 8'h00, 8'h00, 0,    0,  0, 2, 12);
        vecs[6] = mk(0, 7'h30, 16'h0000, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0,    1,  0, 0, 4);
        vecs[7] = mk(0, 7'h29, 16'h0010, 1, 8'h02, 1, 0, 1, 8'h00, 8'h00, 0,    0,  0, 1, 10);
        exp_logs[0] = '{L_S, 'h52, L_A, 'hA6, L_A, 'hA6, L_A, L_S, 'h53, L_A, 'h12, L_A, 'h34, L_N, L_P, X};
        exp_logs[1] = '{L_S, 'h52, L_A, 'h00, L_A, 'h10, L_A, 'h02, L_A, L_P, X, X, X, X, X, X};
        exp_logs[2] = '{L_S, 'h52, L_N, L_P, X, X, X, X, X, X, X, X, X, X, X, X};
        exp_logs[3] = '{L_S, 'h52, L_A, 'h00, L_A, 'h01, L_A, L_S, 'h53, L_A, 'h5A, L_N, L_P, X, X, X};
        exp_logs[4] = '{L_S, 'h52, L_A, 'h12, L_A, 'h34, L_A, L_P, X, X, X, X, X, X, X, X};
        exp_logs[5] = '{L_S, 'h52, L_A, 'hAB, L_A, 'hCD, L_A, 'h77, L_A, 'h77, L_A, L_P, X, X, X, X};
        exp_logs[6] = '{L_S, 'h60, L_N, L_P, X, X, X, X, X, X, X, X, X, X, X, X};
        exp_logs[7] = exp_logs[1];

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_scl_t", int'(SCL_t), 1);
        chk("rst_sda_t", int'(SDA_t), 1);
        chk("rst_scl_out", int'(SCL_out), 0);
        chk("rst_sda_out", int'(SDA_out), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_error", int'(error_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_data_req", int'(data_req), 0);

        // Reset in the middle of a transfer that has already flagged a NACK
        cur_present = 1'b0; cur_stretch = 1'b0;
        is_read = 1'b0; slave_adress = 7'h29; register_address = 16'h0000;
        nb_of_bytes = 10'd1; data_in = 8'h00; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!error_out && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        chk("midrst_err_seen", int'(error_out), 1);
        chk("midrst_busy", int'(ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_scl_t", int'(SCL_t), 1);
        chk("midrst_sda_t", int'(SDA_t), 1);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_error", int'(error_out), 0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("postrst_ready", int'(ready), 1);
        chk("postrst_scl_t", int'(SCL_t), 1);
        $display("[TB] mid-transfer reset: ready=%0d error_out=%0d", ready, error_out);

        for (int n = 0; n < NV; n++) run_vec(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_entity.md
Name: i2c_entity

Overview:
- Single-master I2C controller for register-addressed slaves with a 16-bit register pointer, e.g. the ToF sensor at 7-bit address 0x29.
- Host supplies slave address, register address, direction and byte count, then pulses start.
- Block drives open-drain SCL/SDA through external tristate IOBUFs, returns read bytes, and flags slave NACKs.
- Sits between the sensor-control FSM and the board I2C pins.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- I2C_FREQ_HZ, 400_000, target SCL frequency.
- Derived constant DIV = CLK_FREQ_HZ/(4*I2C_FREQ_HZ), the number of clocks per quarter SCL period (62 at defaults). DIV must be at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse; honoured only while ready=1.
- is_read  in  1  1 = register read, 0 = register write.
- slave_adress  in  7  7-bit slave address.
- register_address  in  16  register pointer, sent MSB byte first.
- nb_of_bytes  in  10  number of data bytes to transfer (0..1023).
- data_in  in  8  write data byte.
- SCL_in, SDA_in  in  1 each  pad input values.
- SCL_out, SDA_out  out  1 each  pad output values; tied to constant 0 (open-drain).
- SCL_t, SDA_t  out  1 each  tristate controls; 1 = release (high-Z), 0 = drive low.
- ready  out  1  high when idle and able to accept start.
- error_out  out  1  sticky slave-NACK flag.
- data_out  out  8  last byte read.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- data_req  out  1  one-cycle pulse when data_in is latched for a write byte.

Behaviour:
- Reset values (asynchronous assertion):
  - SCL_t=1, SDA_t=1.
  - ready=1, error_out=0, data_out=0, data_valid=0, data_req=0.
  - FSM returns to IDLE from any state; the bus is released immediately, with no STOP generated.
- Start acceptance:
  - start=1 in IDLE latches all request inputs, clears error_out, and drops ready on the next cycle.
  - start while busy is ignored.
- Bit timing:
  - Each bit is 4 phases of DIV clocks: SCL low/data setup, SCL release, SCL high, SCL pull low.
  - SDA changes only while SCL is low.
  - Clock stretching: after releasing SCL, the phase counter holds until SCL_in=1 (2-FF synchronised SCL_in/SDA_in).
  - Slave/ack data is sampled at the middle of the SCL-high phase.
- FSM states: IDLE, START, SEND_BYTE, GET_ACK, RESTART, READ_BYTE, SEND_ACK, STOP.
- Write sequence:
  - START, then {addr,0}, ACK, reg[15:8], ACK, reg[7:0], ACK.
  - Then nb_of_bytes bytes from data_in, each followed by ACK, then STOP.
  - data_in is latched at the start of each data byte, with a data_req pulse on the same cycle.
  - nb_of_bytes=0: pointer-only write, then STOP.
- Read sequence:
  - START, {addr,0}, ACK, reg hi, ACK, reg lo, ACK.
  - Then RESTART, {addr,1}, ACK.
  - Then nb_of_bytes bytes read MSB-first, with SDA released during the byte.
  - Master ACKs (drives SDA low) every byte except the last, which gets NACK (SDA released). Then STOP.
  - data_out and data_valid update after bit 0 is sampled, before the master ACK bit.
  - nb_of_bytes=0 with is_read=1: behaves as a pointer-only write (no RESTART), then STOP.
- START condition: with SCL high, SDA is pulled low; one quarter later SCL is pulled low.
- STOP condition: SDA low, SCL released, then SDA released while SCL is high. Return to IDLE after a further DIV clocks of bus-free time.
- ACK check: slave must pull SDA low in every GET_ACK. On NACK:
  - error_out is set;
  - the FSM goes directly to STOP, skipping remaining bytes;
  - ready returns to 1 after the STOP.
- error_out stays high until the next accepted start or reset.
- ready rises on the same cycle the FSM re-enters IDLE.
- Byte counter is 10 bits wide; the full 1023-byte range is supported with no wrap.

Test Plan:
- Reset asserted for one cycle mid-transfer: next cycle SCL_t=1, SDA_t=1, ready=1, error_out=0, and the block accepts a new start.
- Read, slave 0x29, reg 0xA6A6, nb_of_bytes=2, slave model ACKs and returns 0x12, 0x34:
  - bus bytes 0x52, 0xA6, 0xA6, repeated start, 0x53;
  - data_valid pulses twice with 0x12 then 0x34;
  - master ACK after the first byte, NACK after the last, then STOP;
  - ready=1, error_out=0.
- Write, reg 0x0010, nb_of_bytes=1, data_in=0x02:
  - bus 0x52, 0x00, 0x10, 0x02 with 4 ACKs, then STOP;
  - one data_req pulse.
- Absent slave (SDA never pulled low):
  - NACK after 0x52, immediate STOP, error_out=1, ready=1;
  - the next start clears error_out.
- Slave holds SCL low for 500 clocks during the second bit: the transfer stalls, then completes with correct data.
- start pulsed while ready=0: ignored; bus waveform is identical to the single-start case.
